// File: rtl/adc_pkg.sv
// Shared types and default constants for the serial ADC sampler.
// Imported by adc_sampler and sclk_gen.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } adc_state_t;

    localparam int DEF_DBITS      = 12;
    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_LEAD_BITS  = 4;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_QUIET_CYC  = 16;
    localparam int DEF_WR_HIGH    = 4;

endpackage

// File: rtl/adc_sampler_sclk_gen.sv
// SCLK half-period timer: ticks every CLK_DIV cycles while enabled,
// toggling the serial clock level and counting edges.
module sclk_gen
    import adc_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int EW      = 6
) (
    input  logic          SYS_CLK,
    input  logic          reset,
    input  logic          en,
    output logic          tick,
    output logic          sclk_next,
    output logic [EW-1:0] edges
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          level;

    assign tick      = en && (cnt == '0);
    assign sclk_next = tick ? ~level : level;

    // Down-counter; parked at reload with sclk high while disabled.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            cnt   <= RELOAD;
            level <= 1'b1;
            edges <= '0;
        end else if (!en) begin
            cnt   <= RELOAD;
            level <= 1'b1;
            edges <= '0;
        end else if (tick) begin
            cnt   <= RELOAD;
            level <= ~level;
            edges <= edges + 1'b1;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/adc_sampler.sv
// Serial ADC front end: frames CS/SCLK, captures DBITS of each frame,
// and hands samples to the FIFO with a stretched wr strobe.
module adc_sampler
    import adc_pkg::*;
#(
    parameter int DBITS      = DEF_DBITS,
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int LEAD_BITS  = DEF_LEAD_BITS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int QUIET_CYC  = DEF_QUIET_CYC,
    parameter int WR_HIGH    = DEF_WR_HIGH
) (
    input  logic             SYS_CLK,
    input  logic             reset,
    input  logic             enable,
    input  logic             adc_sdata,
    input  logic             full,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic [DBITS-1:0] sample,
    output logic             wr,
    output logic             overrun,
    output logic [7:0]       overrun_count
);

    localparam int EW   = $clog2(2 * FRAME_BITS + 1);
    localparam int WMAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int WW   = $clog2(WMAX + 1);
    localparam int HW   = $clog2(WR_HIGH + 1);

    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * FRAME_BITS - 1);
    localparam logic [EW-1:0] CAP_LO    = EW'(2 * LEAD_BITS + 1);
    localparam logic [EW-1:0] CAP_HI    = EW'(2 * (LEAD_BITS + DBITS) - 1);

    adc_state_t       state;
    adc_state_t       state_nxt;
    logic [WW-1:0]    wait_cnt;
    logic             wait_done;
    logic             tick;
    logic             sclk_nxt;
    logic [EW-1:0]    edges;
    logic             cap_en;
    logic             done_q;
    logic             cs_n_d;
    logic             sclk_d;
    logic [DBITS-1:0] cap;
    logic [HW-1:0]    wr_cnt;

    sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .EW      (EW)
    ) u_sclk_gen (
        .SYS_CLK   (SYS_CLK),
        .reset     (reset),
        .en        (state == SHIFT),
        .tick      (tick),
        .sclk_next (sclk_nxt),
        .edges     (edges)
    );

    assign wait_done = (wait_cnt == '0);

    // Odd edge counts are rising edges; only the sample window shifts in.
    assign cap_en = tick && sclk_nxt
                 && (edges >= CAP_LO) && (edges <= CAP_HI);

    // State register.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode; enable only matters in IDLE and at end of QUIET.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (enable) state_nxt = SETUP;
            SETUP: if (wait_done) state_nxt = SHIFT;
            SHIFT: if (tick && edges == LAST_EDGE) state_nxt = QUIET;
            QUIET: if (wait_done) state_nxt = enable ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pin levels for the upcoming state, registered below.
    always_comb begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
        unique case (1'b1)
            state_nxt == SETUP: cs_n_d = 1'b0;
            state_nxt == SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_nxt;
            end
            default: ;
        endcase
    end

    // Registered ADC pins.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
        end else begin
            adc_cs_n <= cs_n_d;
            adc_sclk <= sclk_d;
        end
    end

    // Dwell timer for SETUP and QUIET, loaded on every state change.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= (state_nxt == QUIET) ? WW'(QUIET_CYC - 1)
                                             : WW'(CLK_DIV - 1);
        end else if (!wait_done) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // MSB-first capture of the sample window.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset)       cap <= '0;
        else if (cap_en) cap <= {cap[DBITS-2:0], adc_sdata};
    end

    // Flags the first QUIET cycle, where the frame is committed.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= (state == SHIFT) && (state_nxt == QUIET);
    end

    // Frame commit: publish the sample, or drop it and count the overrun.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            sample        <= '0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (done_q) begin
            if (!full) begin
                sample <= cap;
            end else begin
                overrun <= 1'b1;
                if (overrun_count != 8'hFF)
                    overrun_count <= overrun_count + 1'b1;
            end
        end
    end

    // Stretches wr to WR_HIGH cycles for the edge-detecting FIFO.
    always_ff @(posedge SYS_CLK or posedge reset) begin
        if (reset) begin
            wr     <= 1'b0;
            wr_cnt <= '0;
        end else if (done_q && !full) begin
            wr     <= 1'b1;
            wr_cnt <= HW'(WR_HIGH - 1);
        end else if (wr_cnt != '0) begin
            wr_cnt <= wr_cnt - 1'b1;
        end else begin
            wr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_sampler.sv
// Randomized bench for adc_sampler: an ADC serial model feeds frames,
// a pin monitor records timing, and a frame-level model predicts results.
module tb_adc_sampler;

    localparam int DBITS      = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 4;
    localparam int CLK_DIV    = 4;
    localparam int QUIET_CYC  = 16;
    localparam int WR_HIGH    = 4;
    localparam int CS_LOW     = CLK_DIV + 2 * FRAME_BITS * CLK_DIV;
    localparam int PERIOD     = CS_LOW + QUIET_CYC;

    logic             SYS_CLK   = 1'b0;
    logic             reset     = 1'b1;
    logic             enable    = 1'b0;
    logic             adc_sdata = 1'b0;
    logic             full      = 1'b0;
    logic             adc_cs_n;
    logic             adc_sclk;
    logic [DBITS-1:0] sample;
    logic             wr;
    logic             overrun;
    logic [7:0]       overrun_count;

    adc_sampler #(
        .DBITS      (DBITS),
        .FRAME_BITS (FRAME_BITS),
        .LEAD_BITS  (LEAD_BITS),
        .CLK_DIV    (CLK_DIV),
        .QUIET_CYC  (QUIET_CYC),
        .WR_HIGH    (WR_HIGH)
    ) dut (
        .SYS_CLK       (SYS_CLK),
        .reset         (reset),
        .enable        (enable),
        .adc_sdata     (adc_sdata),
        .full          (full),
        .adc_cs_n      (adc_cs_n),
        .adc_sclk      (adc_sclk),
        .sample        (sample),
        .wr            (wr),
        .overrun       (overrun),
        .overrun_count (overrun_count)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge SYS_CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DBITS-1:0] exp_sample(input logic [FRAME_BITS-1:0] f);
        logic [FRAME_BITS-1:0] s;
        s = f >> (FRAME_BITS - LEAD_BITS - DBITS);
        return s[DBITS-1:0];
    endfunction

    // ADC model: first bit after the first sclk fall, next bit on each fall.
    logic [FRAME_BITS-1:0] tx_q[$];
    logic [FRAME_BITS-1:0] cur = '0;
    int                    nf  = 0;
    logic                  acs_p = 1'b1;
    logic                  asc_p = 1'b1;

    always @(negedge SYS_CLK) begin
        if (!adc_cs_n && acs_p) begin
            if (tx_q.size() > 0) cur = tx_q.pop_front();
            else                 cur = FRAME_BITS'($urandom);
            nf = 0;
        end else if (!adc_cs_n && !adc_sclk && asc_p) begin
            nf++;
            if (nf <= FRAME_BITS) adc_sdata = cur[FRAME_BITS-nf];
            else                  adc_sdata = 1'b0;
        end
        acs_p = adc_cs_n;
        asc_p = adc_sclk;
    end

    // Pin monitor.
    int               cs_fall_q[$];
    int               cs_len_q[$];
    int               rise_cnt_q[$];
    int               last_rise_q[$];
    int               wr_cyc_q[$];
    int               wr_len_q[$];
    logic [DBITS-1:0] wr_smp_q[$];
    int               cs_fall_at = 0;
    int               rises      = 0;
    int               last_rise  = 0;
    int               wr_at      = 0;
    logic             cs_p   = 1'b1;
    logic             sclk_p = 1'b1;
    logic             wr_p   = 1'b0;

    always @(negedge SYS_CLK) begin
        if (reset) begin
            cs_p   = 1'b1;
            sclk_p = 1'b1;
            wr_p   = 1'b0;
        end else begin
            if (adc_sclk && !sclk_p && (!adc_cs_n || !cs_p)) begin
                rises++;
                last_rise = cyc;
            end
            if (!adc_cs_n && cs_p) begin
                cs_fall_q.push_back(cyc);
                cs_fall_at = cyc;
                rises = 0;
            end
            if (adc_cs_n && !cs_p) begin
                cs_len_q.push_back(cyc - cs_fall_at);
                rise_cnt_q.push_back(rises);
                last_rise_q.push_back(last_rise);
            end
            if (wr && !wr_p) begin
                wr_cyc_q.push_back(cyc);
                wr_smp_q.push_back(sample);
                wr_at = cyc;
            end
            if (!wr && wr_p) wr_len_q.push_back(cyc - wr_at);
            cs_p   = adc_cs_n;
            sclk_p = adc_sclk;
            wr_p   = wr;
        end
    end

    // Frame-level model state.
    logic [DBITS-1:0] m_smp = '0;
    bit               m_ov  = 1'b0;
    int               m_cnt = 0;

    logic [FRAME_BITS-1:0] b_fr[$];
    bit                    b_fl[$];

    task automatic wait_cs(input logic v, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge SYS_CLK);
            if (adc_cs_n == v) break;
        end
        chk("wait_cs", adc_cs_n, v);
    endtask

    task automatic wait_rises(input int n, input int lim);
        int   cnt;
        logic p;
        cnt = 0;
        p   = adc_sclk;
        for (int i = 0; i < lim && cnt < n; i++) begin
            @(negedge SYS_CLK);
            if (adc_sclk && !p) cnt++;
            p = adc_sclk;
        end
        chk("wait_sclk", cnt, n);
    endtask

    task automatic run_batch();
        int n;
        int k;
        int idle_lo;
        int exp_k[$];
        n = b_fr.size();
        cs_fall_q.delete();
        cs_len_q.delete();
        rise_cnt_q.delete();
        last_rise_q.delete();
        wr_cyc_q.delete();
        wr_len_q.delete();
        wr_smp_q.delete();
        foreach (b_fr[i]) tx_q.push_back(b_fr[i]);
        enable = 1'b1;
        for (int f = 0; f < n; f++) begin
            wait_cs(1'b0, PERIOD + 20);
            full = b_fl[f];
            if (f == n - 1) begin
                wait_rises(5, 200);
                enable = 1'b0;
            end
            wait_cs(1'b1, CS_LOW + 20);
            repeat (3) @(negedge SYS_CLK);
            if (!b_fl[f]) begin
                m_smp = exp_sample(b_fr[f]);
                exp_k.push_back(f);
            end else begin
                m_ov = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            chk("sample", sample, m_smp);
            chk("overrun", overrun, m_ov);
            chk("ovr_cnt", overrun_count, m_cnt);
        end
        idle_lo = 0;
        repeat (200) begin
            @(negedge SYS_CLK);
            if (!adc_cs_n) idle_lo++;
        end
        chk("idle_cs", idle_lo, 0);
        full = 1'b0;
        chk("frames", cs_fall_q.size(), n);
        for (int i = 0; i < cs_len_q.size(); i++) begin
            chk("cs_low", cs_len_q[i], CS_LOW);
            chk("rises", rise_cnt_q[i], FRAME_BITS);
            if (i > 0 && i < cs_fall_q.size())
                chk("period", cs_fall_q[i] - cs_fall_q[i-1], PERIOD);
        end
        chk("wr_n", wr_cyc_q.size(), exp_k.size());
        for (int j = 0; j < wr_cyc_q.size() && j < exp_k.size(); j++) begin
            k = exp_k[j];
            chk("wr_smp", wr_smp_q[j], exp_sample(b_fr[k]));
            if (k < last_rise_q.size())
                chk("wr_dly", wr_cyc_q[j] - last_rise_q[k], 1);
            if (j < wr_len_q.size())
                chk("wr_len", wr_len_q[j], WR_HIGH);
            if (j > 0)
                chk("wr_gap", wr_cyc_q[j] - wr_cyc_q[j-1], PERIOD * (k - exp_k[j-1]));
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 1);
        chk("rst_sample", sample, 0);
        chk("rst_wr", wr, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ovr_cnt", overrun_count, 0);
        reset = 1'b0;
        @(negedge SYS_CLK);

        b_fr = '{16'h0ABC};
        b_fl = '{1'b0};
        run_batch();

        b_fr = '{16'h0001, 16'h0FFF, 16'h0800};
        b_fl = '{1'b0, 1'b0, 1'b0};
        run_batch();

        b_fr.delete();
        b_fl = '{1'b0, 1'b1, 1'b0};
        repeat (3) b_fr.push_back(FRAME_BITS'($urandom));
        run_batch();

        b_fr.delete();
        b_fl.delete();
        repeat (300) begin
            b_fr.push_back(FRAME_BITS'($urandom));
            b_fl.push_back(1'b1);
        end
        run_batch();

        b_fr.delete();
        b_fl.delete();
        repeat (6) begin
            b_fr.push_back(FRAME_BITS'($urandom));
            b_fl.push_back($urandom_range(0, 3) == 0);
        end
        run_batch();

        tx_q.push_back(FRAME_BITS'($urandom));
        enable = 1'b1;
        wait_cs(1'b0, PERIOD + 20);
        wait_rises(8, 200);
        repeat (CLK_DIV + 1) @(negedge SYS_CLK);
        #2 reset = 1'b1;
        #1;
        chk("mid_cs_n", adc_cs_n, 1);
        chk("mid_sclk", adc_sclk, 1);
        chk("mid_wr", wr, 0);
        chk("mid_sample", sample, 0);
        chk("mid_ovr", overrun, 0);
        chk("mid_ovr_cnt", overrun_count, 0);
        enable = 1'b0;
        tx_q.delete();
        repeat (2) @(negedge SYS_CLK);
        m_smp = '0;
        m_ov  = 1'b0;
        m_cnt = 0;
        reset = 1'b0;
        @(negedge SYS_CLK);

        b_fr = '{FRAME_BITS'($urandom)};
        b_fl = '{1'b0};
        run_batch();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
